lc3_fetch: RTL and testbench

LC3_FETCH -- requirements
Module: lc3_fetch

---
 rtl/lc3_pkg.sv | 37 +++
 rtl/lc3_next_pc.sv | 34 +++
 rtl/lc3_fetch.sv | 61 ++++++
 tb/tb_lc3_fetch.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/lc3_pkg.sv
// Shared LC-3 definitions: word/field widths, opcode encodings and field helpers.
package lc3_pkg;

    localparam int unsigned WORD_W   = 16;
    localparam int unsigned OPCODE_W = 4;
    localparam int unsigned OFFSET_W = 9;
    localparam int unsigned TRAPV_W  = 8;
    localparam int unsigned NZP_W    = 3;

    localparam logic [OPCODE_W-1:0] OP_BR   = 4'b0000;
    localparam logic [OPCODE_W-1:0] OP_ADD  = 4'b0001;
    localparam logic [OPCODE_W-1:0] OP_LD   = 4'b0010;
    localparam logic [OPCODE_W-1:0] OP_ST   = 4'b0011;
    localparam logic [OPCODE_W-1:0] OP_JSR  = 4'b0100;
    localparam logic [OPCODE_W-1:0] OP_AND  = 4'b0101;
    localparam logic [OPCODE_W-1:0] OP_LDR  = 4'b0110;
    localparam logic [OPCODE_W-1:0] OP_STR  = 4'b0111;
    localparam logic [OPCODE_W-1:0] OP_RTI  = 4'b1000;
    localparam logic [OPCODE_W-1:0] OP_NOT  = 4'b1001;
    localparam logic [OPCODE_W-1:0] OP_LDI  = 4'b1010;
    localparam logic [OPCODE_W-1:0] OP_STI  = 4'b1011;
    localparam logic [OPCODE_W-1:0] OP_JMP  = 4'b1100;
    localparam logic [OPCODE_W-1:0] OP_RES  = 4'b1101;
    localparam logic [OPCODE_W-1:0] OP_LEA  = 4'b1110;
    localparam logic [OPCODE_W-1:0] OP_TRAP = 4'b1111;

    // Sign-extend a PCoffset9 field to a full word.
    function automatic logic [WORD_W-1:0] sext_off9(input logic [OFFSET_W-1:0] off);
        return {{(WORD_W - OFFSET_W){off[OFFSET_W-1]}}, off};
    endfunction

    // Zero-extend the trapvect8 portion of the offset field.
    function automatic logic [WORD_W-1:0] zext_trapv(input logic [OFFSET_W-1:0] off);
        return {{(WORD_W - TRAPV_W){1'b0}}, off[TRAPV_W-1:0]};
    endfunction

endpackage

// File: rtl/lc3_next_pc.sv
// Combinational next-PC selection for the LC-3 fetch stage.
module lc3_next_pc
    import lc3_pkg::*;
(
    input  logic [WORD_W-1:0]   pc,
    input  logic [OPCODE_W-1:0] opcode,
    input  logic [OFFSET_W-1:0] offset,
    input  logic [WORD_W-1:0]   reg_val,
    input  logic [NZP_W-1:0]    br_nzp,
    input  logic [NZP_W-1:0]    result_nzp,
    output logic [WORD_W-1:0]   next_pc
);

    logic [WORD_W-1:0] pc_inc;
    logic [WORD_W-1:0] br_target;
    logic              br_taken;

    // Sums truncate to WORD_W, giving modulo-2^16 wrap for free.
    assign pc_inc    = pc + WORD_W'(1);
    assign br_target = pc_inc + sext_off9(offset);
    assign br_taken  = |(br_nzp & result_nzp);

    always_comb begin
        next_pc = pc_inc;
        case (opcode)
            OP_BR:   next_pc = br_taken ? br_target : pc_inc;
            OP_JMP:  next_pc = reg_val;
            OP_JSR:  next_pc = reg_val;
            OP_TRAP: next_pc = zext_trapv(offset);
            default: next_pc = pc_inc;
        endcase
    end

endmodule

// File: rtl/lc3_fetch.sv
// LC-3 instruction fetch: PC and memory address registers, updated on each
// cycle fetch_start is high; the fetch port never writes.
module lc3_fetch
    import lc3_pkg::*;
(
    input  logic                clk,
    input  logic                rst_n,
    input  logic                fetch_start,
    input  logic [OPCODE_W-1:0] opCode_in,
    input  logic [OFFSET_W-1:0] offset_in,
    input  logic [WORD_W-1:0]   reg_in,
    input  logic [NZP_W-1:0]    br_nzp,
    input  logic [NZP_W-1:0]    result_nzp,
    output logic [WORD_W-1:0]   addr_out,
    output logic                wea_out,
    output logic [WORD_W-1:0]   pc
);

    logic [WORD_W-1:0] pc_q, pc_d;
    logic [WORD_W-1:0] addr_q, addr_d;
    logic              wea_q, wea_d;
    logic [WORD_W-1:0] next_pc;

    lc3_next_pc u_next_pc (
        .pc         (pc_q),
        .opcode     (opCode_in),
        .offset     (offset_in),
        .reg_val    (reg_in),
        .br_nzp     (br_nzp),
        .result_nzp (result_nzp),
        .next_pc    (next_pc)
    );

    // Hold unless a fetch is requested; address always tracks the new PC.
    always_comb begin
        pc_d   = pc_q;
        addr_d = addr_q;
        wea_d  = 1'b0;
        if (fetch_start) begin
            pc_d   = next_pc;
            addr_d = next_pc;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q   <= '0;
            addr_q <= '0;
            wea_q  <= 1'b0;
        end else begin
            pc_q   <= pc_d;
            addr_q <= addr_d;
            wea_q  <= wea_d;
        end
    end

    assign pc       = pc_q;
    assign addr_out = addr_q;
    assign wea_out  = wea_q;

endmodule

// File: tb/tb_lc3_fetch.sv
// Directed self-checking bench for lc3_fetch.
module tb_lc3_fetch;

    logic        clk;
    logic        rst_n;
    logic        fetch_start;
    logic [3:0]  opCode_in;
    logic [8:0]  offset_in;
    logic [15:0] reg_in;
    logic [2:0]  br_nzp;
    logic [2:0]  result_nzp;
    logic [15:0] addr_out;
    logic        wea_out;
    logic [15:0] pc;

    int checks;
    int failures;

    lc3_fetch dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .fetch_start (fetch_start),
        .opCode_in   (opCode_in),
        .offset_in   (offset_in),
        .reg_in      (reg_in),
        .br_nzp      (br_nzp),
        .result_nzp  (result_nzp),
        .addr_out    (addr_out),
        .wea_out     (wea_out),
        .pc          (pc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive one cycle of inputs at the falling edge, return just after the rising edge.
    task automatic step(input logic fs, input logic [3:0] op, input logic [8:0] off,
                        input logic [15:0] rv, input logic [2:0] bn, input logic [2:0] rn);
        @(negedge clk);
        fetch_start = fs;
        opCode_in   = op;
        offset_in   = off;
        reg_in      = rv;
        br_nzp      = bn;
        result_nzp  = rn;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        fetch_start = 1'b0;
        opCode_in = 4'b0011;
        offset_in = 9'h0;
        reg_in = 16'h0;
        br_nzp = 3'b0;
        result_nzp = 3'b0;
        repeat (5) @(posedge clk);
        #1;
        checks++;
        if (pc !== 16'h0 || addr_out !== 16'h0 || wea_out !== 1'b0) begin
            failures++;
            $display("FAIL reset_hold pc=%h addr=%h wea=%b expected 0000/0000/0", pc, addr_out, wea_out);
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 4'b0011, 9'h0, 16'h0, 3'b0, 3'b0);
            checks++;
            if (pc !== 16'h0 || addr_out !== 16'h0 || wea_out !== 1'b0) begin
                failures++;
                $display("FAIL reset_release[%0d] pc=%h addr=%h wea=%b expected 0000/0000/0",
                         i, pc, addr_out, wea_out);
            end
        end
    endtask

    task automatic test_sequential;
        for (int i = 1; i <= 3; i++) begin
            step(1'b1, 4'b0001, 9'h0, 16'h0, 3'b0, 3'b0);
            checks++;
            if (pc !== 16'(i) || addr_out !== 16'(i) || wea_out !== 1'b0) begin
                failures++;
                $display("FAIL seq[%0d] pc=%h addr=%h wea=%b expected %h/%h/0",
                         i, pc, addr_out, wea_out, 16'(i), 16'(i));
            end
        end
    endtask

    task automatic test_hold;
        for (int i = 0; i < 2; i++) begin
            step(1'b0, 4'b1100, 9'h1AB, 16'hABCD, 3'b111, 3'b111);
            checks++;
            if (pc !== 16'h0003 || addr_out !== 16'h0003 || wea_out !== 1'b0) begin
                failures++;
                $display("FAIL hold[%0d] pc=%h addr=%h wea=%b expected 0003/0003/0",
                         i, pc, addr_out, wea_out);
            end
        end
    endtask

    task automatic test_branch;
        logic [15:0] exp_pc [7];
        step(1'b1, 4'b1100, 9'h0, 16'h0010, 3'b0, 3'b0);            // -> 0010
        exp_pc[0] = 16'h0010;
        checks++;
        if (pc !== exp_pc[0]) begin
            failures++;
            $display("FAIL br_setup pc=%h expected %h", pc, exp_pc[0]);
        end
        step(1'b1, 4'b0000, 9'h1FE, 16'h0, 3'b010, 3'b010);         // taken, -2
        checks++;
        if (pc !== 16'h000F || addr_out !== 16'h000F) begin
            failures++;
            $display("FAIL br_taken_neg pc=%h addr=%h expected 000F", pc, addr_out);
        end
        step(1'b1, 4'b1100, 9'h0, 16'h0010, 3'b0, 3'b0);
        step(1'b1, 4'b0000, 9'h1FE, 16'h0, 3'b010, 3'b001);         // not taken
        checks++;
        if (pc !== 16'h0011) begin
            failures++;
            $display("FAIL br_not_taken pc=%h expected 0011", pc);
        end
        step(1'b1, 4'b0000, 9'h0F0, 16'h0, 3'b000, 3'b111);         // nzp=000 never
        checks++;
        if (pc !== 16'h0012) begin
            failures++;
            $display("FAIL br_nzp000 pc=%h expected 0012", pc);
        end
        step(1'b1, 4'b0000, 9'h005, 16'h0, 3'b111, 3'b100);         // 0012+1+5
        checks++;
        if (pc !== 16'h0018) begin
            failures++;
            $display("FAIL br_nzp111 pc=%h expected 0018", pc);
        end
        step(1'b1, 4'b0000, 9'h0FF, 16'h0, 3'b100, 3'b100);         // 0018+1+FF
        checks++;
        if (pc !== 16'h0118 || addr_out !== 16'h0118) begin
            failures++;
            $display("FAIL br_pos_max pc=%h addr=%h expected 0118", pc, addr_out);
        end
    endtask

    task automatic test_jump_trap;
        step(1'b1, 4'b1100, 9'h0, 16'h3000, 3'b0, 3'b0);
        checks++;
        if (pc !== 16'h3000 || addr_out !== 16'h3000 || wea_out !== 1'b0) begin
            failures++;
            $display("FAIL jmp pc=%h addr=%h wea=%b expected 3000/3000/0", pc, addr_out, wea_out);
        end
        step(1'b1, 4'b0100, 9'h0, 16'h1234, 3'b0, 3'b0);
        checks++;
        if (pc !== 16'h1234) begin
            failures++;
            $display("FAIL jsrr pc=%h expected 1234", pc);
        end
        step(1'b1, 4'b1111, 9'h025, 16'h0, 3'b0, 3'b0);
        checks++;
        if (pc !== 16'h0025 || addr_out !== 16'h0025) begin
            failures++;
            $display("FAIL trap pc=%h addr=%h expected 0025", pc, addr_out);
        end
        step(1'b1, 4'b1111, 9'h1FF, 16'h0, 3'b0, 3'b0);             // bit 8 ignored
        checks++;
        if (pc !== 16'h00FF) begin
            failures++;
            $display("FAIL trap_zext pc=%h expected 00FF", pc);
        end
        step(1'b1, 4'b1000, 9'h1F0, 16'h5555, 3'b111, 3'b111);      // RTI -> +1
        checks++;
        if (pc !== 16'h0100) begin
            failures++;
            $display("FAIL rti pc=%h expected 0100", pc);
        end
        step(1'b1, 4'b1101, 9'h1F0, 16'h5555, 3'b111, 3'b111);      // reserved -> +1
        checks++;
        if (pc !== 16'h0101) begin
            failures++;
            $display("FAIL reserved pc=%h expected 0101", pc);
        end
    endtask

    task automatic test_wrap;
        step(1'b1, 4'b1100, 9'h0, 16'hFFFF, 3'b0, 3'b0);
        step(1'b1, 4'b0011, 9'h0, 16'h0, 3'b0, 3'b0);
        checks++;
        if (pc !== 16'h0000 || addr_out !== 16'h0000) begin
            failures++;
            $display("FAIL wrap_inc pc=%h addr=%h expected 0000", pc, addr_out);
        end
        step(1'b1, 4'b0000, 9'h1FE, 16'h0, 3'b001, 3'b001);         // 0+1-2
        checks++;
        if (pc !== 16'hFFFF) begin
            failures++;
            $display("FAIL wrap_neg pc=%h expected FFFF", pc);
        end
    endtask

    task automatic test_back_to_back;
        logic [15:0] exp;
        step(1'b1, 4'b1100, 9'h0, 16'h4000, 3'b0, 3'b0);
        exp = 16'h4000;
        for (int i = 0; i < 5; i++) begin
            step(1'b1, 4'b0110, 9'h0, 16'h0, 3'b0, 3'b0);
            exp = exp + 16'h1;
            checks++;
            if (pc !== exp || addr_out !== exp || wea_out !== 1'b0) begin
                failures++;
                $display("FAIL b2b[%0d] pc=%h addr=%h wea=%b expected %h", i, pc, addr_out, wea_out, exp);
            end
        end
    endtask

    task automatic test_async_reset;
        step(1'b1, 4'b1100, 9'h0, 16'h3000, 3'b0, 3'b0);
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (pc !== 16'h0 || addr_out !== 16'h0 || wea_out !== 1'b0) begin
            failures++;
            $display("FAIL async_reset pc=%h addr=%h wea=%b expected 0000/0000/0", pc, addr_out, wea_out);
        end
        @(posedge clk);
        #1;
        checks++;
        if (pc !== 16'h0 || addr_out !== 16'h0) begin
            failures++;
            $display("FAIL reset_over_fetch pc=%h addr=%h expected 0000", pc, addr_out);
        end
        @(negedge clk);
        fetch_start = 1'b0;
        rst_n = 1'b1;
        step(1'b0, 4'b1100, 9'h0, 16'h1234, 3'b0, 3'b0);
        step(1'b0, 4'b1111, 9'h025, 16'h0, 3'b0, 3'b0);
        checks++;
        if (pc !== 16'h0 || addr_out !== 16'h0 || wea_out !== 1'b0) begin
            failures++;
            $display("FAIL post_reset_idle pc=%h addr=%h wea=%b expected 0000/0000/0", pc, addr_out, wea_out);
        end
    endtask

    initial begin
        checks = 0;
        failures = 0;
        test_reset();
        test_sequential();
        test_hold();
        test_branch();
        test_jump_trap();
        test_wrap();
        test_back_to_back();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
